// File: rtl/bnw_game_pkg.sv
// Shared constants and helpers for the falling-block note game.
// Heights grow downward from spawn (H_START) to the floor (H_END).
package bnw_game_pkg;

  localparam int HW        = 10;
  localparam int BEAT_W    = 7;
  localparam int STEP_W    = 3;
  localparam int H_START_D = 120;
  localparam int H_END_D   = 720;
  localparam int HIT_LO_D  = 600;

  typedef logic [HW-1:0]     height_t;
  typedef logic [STEP_W-1:0] step_t;

  // Advance a height by step, clamping at the floor.
  function automatic height_t sat_step(
    input height_t h,
    input step_t   st,
    input height_t lim
  );
    logic [HW:0] sum;
    sum = {1'b0, h} + {{(HW+1-STEP_W){1'b0}}, st};
    return (sum >= {1'b0, lim}) ? lim : sum[HW-1:0];
  endfunction

endpackage

// File: rtl/lane_slot_ctrl.sv
// One note lane: slot allocation, fall motion, hit judging and expiry.
// Invalid slots park at the floor height so the display reads H_END.
module lane_slot_ctrl
  import bnw_game_pkg::*;
#(
  parameter int SLOTS   = 2,
  parameter int H_START = H_START_D,
  parameter int H_END   = H_END_D,
  parameter int HIT_LO  = HIT_LO_D
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            frz_i,
  input  logic            spawn_i,
  input  logic            hit_i,
  input  step_t           step_i,
  output logic [SLOTS*HW-1:0] h_o,
  output logic [SLOTS-1:0] vld_o,
  output logic            hit_ok_o,
  output logic            hit_bad_o,
  output logic            miss_o,
  output logic            drop_o
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam height_t HS = height_t'(H_START);
  localparam height_t HE = height_t'(H_END);
  localparam height_t HL = height_t'(HIT_LO);

  height_t          h_q [SLOTS];
  height_t          h_d [SLOTS];
  logic [SLOTS-1:0] vld_q, vld_d;
  logic             ok_q, ok_d;
  logic             bad_q, bad_d;
  logic             miss_q, miss_d;

  logic             tgt_fnd;
  logic [SW-1:0]    tgt;
  height_t          tgt_h;
  logic             free_fnd;
  logic [SW-1:0]    free;
  logic             hit_good;

  // Hit target: deepest valid slot, lowest index on ties.
  always_comb begin
    tgt_fnd  = 1'b0;
    tgt      = '0;
    tgt_h    = '0;
    free_fnd = 1'b0;
    free     = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (vld_q[s] && (!tgt_fnd || h_q[s] > tgt_h)) begin
        tgt_fnd = 1'b1;
        tgt     = SW'(s);
        tgt_h   = h_q[s];
      end
      if (!vld_q[s] && !free_fnd) begin
        free_fnd = 1'b1;
        free     = SW'(s);
      end
    end
  end

  assign hit_good = hit_i && tgt_fnd && (tgt_h >= HL);

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      h_d[s]   = h_q[s];
      vld_d[s] = vld_q[s];
    end
    ok_d   = 1'b0;
    bad_d  = 1'b0;
    miss_d = 1'b0;
    drop_o = 1'b0;
    if (!frz_i) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (vld_q[s]) begin
          if (hit_good && tgt == SW'(s)) begin
            vld_d[s] = 1'b0;
            h_d[s]   = HE;
          end else if (h_q[s] == HE) begin
            vld_d[s] = 1'b0;
            h_d[s]   = HE;
            miss_d   = 1'b1;
          end else begin
            h_d[s] = sat_step(h_q[s], step_i, HE);
          end
        end
      end
      ok_d  = hit_good;
      bad_d = hit_i && !hit_good;
      // Allocation looks only at cycle-start occupancy.
      if (spawn_i) begin
        if (free_fnd) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (free == SW'(s)) begin
              vld_d[s] = 1'b1;
              h_d[s]   = HS;
            end
          end
        end else begin
          drop_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int s = 0; s < SLOTS; s++) h_q[s] <= HE;
      vld_q  <= '0;
      ok_q   <= 1'b0;
      bad_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      for (int s = 0; s < SLOTS; s++) h_q[s] <= h_d[s];
      vld_q  <= vld_d;
      ok_q   <= ok_d;
      bad_q  <= bad_d;
      miss_q <= miss_d;
    end
  end

  always_comb begin
    h_o = '0;
    for (int s = 0; s < SLOTS; s++) h_o[s*HW +: HW] = h_q[s];
  end

  assign vld_o     = vld_q;
  assign hit_ok_o  = ok_q;
  assign hit_bad_o = bad_q;
  assign miss_o    = miss_q;

endmodule

// File: rtl/lane_block_gen.sv
// Multi-lane falling block generator driven by a song beat counter.
// Define LANE_BLOCK_GEN_SPEED_EN to add a 3-bit fall speed input.
module lane_block_gen
  import bnw_game_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SLOTS     = 2,
  parameter int H_START   = H_START_D,
  parameter int H_END     = H_END_D,
  parameter int HIT_LO    = HIT_LO_D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        restart,
  input  logic                        stop_or_endgame,
  input  logic [BEAT_W-1:0]           beat_cnt,
`ifdef LANE_BLOCK_GEN_SPEED_EN
  input  logic [STEP_W-1:0]           speed,
`endif
  input  logic [NUM_LANES-1:0]        spawn_lane,
  input  logic [NUM_LANES-1:0]        hit_lane,
  output logic [NUM_LANES*SLOTS*HW-1:0] block_h,
  output logic [NUM_LANES*SLOTS-1:0]  block_vld,
  output logic [NUM_LANES-1:0]        hit_ok,
  output logic [NUM_LANES-1:0]        hit_bad,
  output logic [NUM_LANES-1:0]        miss,
  output logic                        overflow
);

  logic [BEAT_W-1:0]    beat_q;
  logic                 ovf_q, ovf_d;
  logic                 rst_all;
  logic                 beat_add;
  step_t                step;
  logic [NUM_LANES-1:0] drop;

  assign rst_all  = rst | restart;
  // Strict unsigned compare: a wrap back to a lower count never spawns.
  assign beat_add = beat_cnt > beat_q;

`ifdef LANE_BLOCK_GEN_SPEED_EN
  assign step = speed;
`else
  assign step = step_t'(1);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_slot_ctrl #(
      .SLOTS   (SLOTS),
      .H_START (H_START),
      .H_END   (H_END),
      .HIT_LO  (HIT_LO)
    ) u_lane (
      .clk       (clk),
      .rst_i     (rst_all),
      .frz_i     (stop_or_endgame),
      .spawn_i   (beat_add & spawn_lane[i]),
      .hit_i     (hit_lane[i]),
      .step_i    (step),
      .h_o       (block_h[i*SLOTS*HW +: SLOTS*HW]),
      .vld_o     (block_vld[i*SLOTS +: SLOTS]),
      .hit_ok_o  (hit_ok[i]),
      .hit_bad_o (hit_bad[i]),
      .miss_o    (miss[i]),
      .drop_o    (drop[i])
    );
  end

  assign ovf_d = ovf_q | (|drop);

  always_ff @(posedge clk) begin
    if (rst_all) begin
      beat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      beat_q <= beat_cnt;
      ovf_q  <= ovf_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_lane_block_gen.sv
// Directed bench for lane_block_gen with hand-computed heights/pulses.
// Speed checks compile in when LANE_BLOCK_GEN_SPEED_EN is defined.
module tb_lane_block_gen;

  logic        clk = 1'b0;
  logic        rst, restart, stop_or_endgame;
  logic [6:0]  beat_cnt;
  logic [2:0]  speed;
  logic [3:0]  spawn_lane, hit_lane;
  logic [79:0] block_h;
  logic [7:0]  block_vld;
  logic [3:0]  hit_ok, hit_bad, miss;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  int npls;

  always #5 clk = ~clk;

  lane_block_gen dut (
    .clk             (clk),
    .rst             (rst),
    .restart         (restart),
    .stop_or_endgame (stop_or_endgame),
    .beat_cnt        (beat_cnt),
`ifdef LANE_BLOCK_GEN_SPEED_EN
    .speed           (speed),
`endif
    .spawn_lane      (spawn_lane),
    .hit_lane        (hit_lane),
    .block_h         (block_h),
    .block_vld       (block_vld),
    .hit_ok          (hit_ok),
    .hit_bad         (hit_bad),
    .miss            (miss),
    .overflow        (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (|{hit_ok, hit_bad, miss}) npls++;
    end
  endtask

  function automatic logic [9:0] hgt(input int l, input int s);
    return block_h[(l*2+s)*10 +: 10];
  endfunction

  initial begin
    rst = 1'b1; restart = 1'b0; stop_or_endgame = 1'b0;
    beat_cnt = 7'd5; speed = 3'd1;
    spawn_lane = '0; hit_lane = '0;
    npls = 0;
    tick(2);
    chk("rst_vld", block_vld, 8'h00);
    chk("rst_h00", hgt(0, 0), 720);
    chk("rst_h31", hgt(3, 1), 720);
    chk("rst_ovf", overflow, 0);
    chk("rst_pls", {hit_ok, hit_bad, miss}, 0);

    // first cycle out of reset: 5 > 0 but nothing requested
    rst = 1'b0;
    tick();
    chk("idle_vld", block_vld, 8'h00);

    beat_cnt = 7'd6; spawn_lane = 4'b0001;
    tick();
    spawn_lane = '0;
    chk("sp_vld", block_vld, 8'h01);
    chk("sp_h", hgt(0, 0), 120);
    npls = 0;
    tick(100);
    chk("fall_h220", hgt(0, 0), 220);
    tick(500);
    chk("fall_h720", hgt(0, 0), 720);
    chk("fall_vld", block_vld[0], 1);
    chk("fall_nopls", npls, 0);
    tick();
    chk("exp_vld", block_vld[0], 0);
    chk("exp_miss", miss, 4'b0001);
    chk("exp_h", hgt(0, 0), 720);
    tick();
    chk("exp_miss_off", miss, 0);

    // overflow: third spawn into a two-slot lane is dropped
    spawn_lane = 4'b0010;
    beat_cnt = 7'd7; tick();
    beat_cnt = 7'd8; tick();
    chk("ovf_pre", overflow, 0);
    beat_cnt = 7'd9; tick();
    spawn_lane = '0;
    chk("ovf_vld", block_vld, 8'b0000_1100);
    chk("ovf_h10", hgt(1, 0), 122);
    chk("ovf_h11", hgt(1, 1), 121);
    chk("ovf_set", overflow, 1);
    tick(5);
    chk("ovf_hold", overflow, 1);
    npls = 0;
    restart = 1'b1; tick();
    restart = 1'b0;
    chk("rs_vld", block_vld, 8'h00);
    chk("rs_ovf", overflow, 0);
    chk("rs_h10", hgt(1, 0), 720);
    tick();
    chk("rs_nopls", npls, 0);

    // good hit at 650
    beat_cnt = 7'd10; spawn_lane = 4'b0100; tick();
    spawn_lane = '0;
    chk("h_sp", hgt(2, 0), 120);
    tick(530);
    chk("h_650", hgt(2, 0), 650);
    hit_lane = 4'b0100; tick(); hit_lane = '0;
    chk("h_ok", hit_ok, 4'b0100);
    chk("h_ok_bad", hit_bad, 0);
    chk("h_ok_vld", block_vld, 8'h00);
    chk("h_ok_h", hgt(2, 0), 720);
    tick();
    chk("h_ok_off", hit_ok, 0);

    // early hit at 300, plus a hit into an empty lane
    beat_cnt = 7'd11; spawn_lane = 4'b0100; tick();
    spawn_lane = '0;
    tick(180);
    chk("b_300", hgt(2, 0), 300);
    hit_lane = 4'b1100; tick(); hit_lane = '0;
    chk("b_bad", hit_bad, 4'b1100);
    chk("b_ok", hit_ok, 0);
    chk("b_vld", block_vld, 8'b0001_0000);
    chk("b_h", hgt(2, 0), 301);

    // beat wrap must not spawn
    beat_cnt = 7'd90; tick();
    beat_cnt = 7'd0; spawn_lane = 4'hF; tick();
    spawn_lane = '0;
    chk("wrap_vld", block_vld, 8'b0001_0000);
    chk("wrap_h", hgt(2, 0), 303);
    chk("wrap_ovf", overflow, 0);

    // freeze: beat tracked, spawns/hits ignored
    stop_or_endgame = 1'b1; npls = 0;
    hit_lane = 4'b0100; spawn_lane = 4'b0001;
    beat_cnt = 7'd5;
    tick(); hit_lane = '0;
    tick(49);
    chk("frz_h", hgt(2, 0), 303);
    chk("frz_vld", block_vld, 8'b0001_0000);
    chk("frz_nopls", npls, 0);
    stop_or_endgame = 1'b0;
    tick();
    spawn_lane = '0;
    chk("unfrz_vld", block_vld, 8'b0001_0000);
    chk("unfrz_h", hgt(2, 0), 304);

    // hit arriving while sitting on the floor beats expiry
    tick(416);
    chk("fl_h", hgt(2, 0), 720);
    chk("fl_vld", block_vld[4], 1);
    hit_lane = 4'b0100; tick(); hit_lane = '0;
    chk("fl_ok", hit_ok, 4'b0100);
    chk("fl_miss", miss, 0);
    chk("fl_vld0", block_vld, 8'h00);

`ifdef LANE_BLOCK_GEN_SPEED_EN
    speed = 3'd3;
    beat_cnt = 7'd6; spawn_lane = 4'b1000; tick();
    spawn_lane = '0;
    chk("spd_h0", hgt(3, 0), 120);
    tick(199);
    chk("spd_717", hgt(3, 0), 717);
    tick();
    chk("spd_720", hgt(3, 0), 720);
    tick();
    chk("spd_miss", miss, 4'b1000);
    chk("spd_vld", block_vld, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_block_gen.md
LANE_BLOCK_GEN -- requirements
Module: lane_block_gen

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent note lanes.
REQ-002 Parameter SLOTS, default 2: concurrent falling blocks per lane.
REQ-003 Parameter H_START, default 120: spawn height.
REQ-004 Parameter H_END, default 720: floor height; block expires here.
REQ-005 Parameter HIT_LO, default 600: lowest height counted as a good hit.
REQ-006 Port clk, input, 1: the single clock (beat-tick clock), all logic on its rising edge.
REQ-007 Port rst, input, 1: reset; synchronous, active-high.
REQ-008 Port restart, input, 1: synchronous game restart, same effect as rst.
REQ-009 Port stop_or_endgame, input, 1: freeze motion, spawns and hits.
REQ-010 Port beat_cnt, input, 7: song beat counter.
REQ-011 Port spawn_lane, input, NUM_LANES: lanes that receive a block on a beat increment.
REQ-012 Port hit_lane, input, NUM_LANES: one-cycle player key pulses.
REQ-013 Port block_h, output, NUM_LANES*SLOTS*10: flattened heights, lane-major, slot-minor.
REQ-014 Port block_vld, output, NUM_LANES*SLOTS: slot active flags.
REQ-015 Port hit_ok, hit_bad, miss, output, NUM_LANES each: one-cycle event pulses.
REQ-016 Port overflow, output, 1: sticky flag, spawn dropped because all slots of a lane were busy.

Function
REQ-017 beat_add SHALL be beat_cnt > previous-cycle beat_cnt (strict, unsigned); a wrap to a lower value SHALL NOT trigger.
REQ-018 On beat_add with stop_or_endgame low, each lane with spawn_lane[i]=1 SHALL allocate its lowest-index slot with block_vld=0 at cycle start; next cycle that slot has vld=1, h=H_START.
REQ-019 A spawn into a lane with no free slot SHALL be dropped and SHALL set overflow, held until reset/restart.
REQ-020 Each cycle with stop_or_endgame low, every valid slot with h<H_END SHALL advance by step, saturating at H_END; step = 1 unless REQ-031 applies.
REQ-021 A valid slot with h==H_END at cycle start and stop_or_endgame low SHALL clear vld next cycle and pulse miss[i] for one cycle.
REQ-022 hit_lane[i] with stop_or_endgame low SHALL target the valid slot of lane i with the greatest h (lowest index on ties); h>=HIT_LO clears it and pulses hit_ok[i]; otherwise, or with no valid slot, pulse hit_bad[i] and leave slots unchanged.
REQ-023 Hit and expiry on the same slot in the same cycle: hit wins, hit_ok pulses, miss does not.
REQ-024 Slots freed by hit or expiry SHALL NOT be reallocated in the same cycle; allocation uses cycle-start vld.
REQ-025 Invalid slots SHALL present block_h = H_END.
REQ-026 While stop_or_endgame is high: heights, vld, spawns and hits frozen/ignored; previous-beat register still tracks beat_cnt; no event pulses.
REQ-027 All outputs SHALL be registered; event pulses are one cycle wide, one cycle after the causing input.

Reset
REQ-028 On rst or restart (sampled at clk edge): all block_vld=0, all block_h=H_END, hit_ok=hit_bad=miss=0, overflow=0, previous-beat register=0.
REQ-029 Reset mid-flight SHALL discard all active blocks with no miss pulses; rst and restart are equivalent and have priority over all other inputs.

Configuration
REQ-030 Macro LANE_BLOCK_GEN_SPEED_EN selects variable fall speed.
REQ-031 With the macro defined: extra input speed, 3 bits, step = speed (0 freezes motion but allows spawns/hits); sampled each cycle.
REQ-032 Without the macro: no speed port, step fixed at 1.

Structure
REQ-033 Shared package bnw_game_pkg SHALL hold the height width (10), H_START/H_END/HIT_LO defaults and the beat-count width (7).
REQ-034 One sub-module lane_slot_ctrl SHALL implement one lane (SLOTS slots, allocate, move, hit, expire), instantiated NUM_LANES times; beat_add and overflow live in the top.

Verification
REQ-035 Reset then beat_cnt 5->6 with spawn_lane=4'b0001 -> next cycle lane0 slot0 vld=1, h=120; 600 cycles later h=720; next cycle vld=0, miss[0] pulses once.
REQ-036 Three spawns in lane1 on beats 6,7,8 with SLOTS=2 -> slots 0,1 filled, third dropped, overflow=1 until restart.
REQ-037 Block at h=650, hit_lane[2] pulse -> hit_ok[2] pulses, slot cleared, block_h reads 720; repeat at h=300 -> hit_bad[2], block continues.
REQ-038 beat_cnt 90->0 with spawn_lane all ones -> no spawn; stop_or_endgame high for 50 cycles -> heights unchanged, hits produce no pulses.
REQ-039 Hit pulse arriving in the cycle h==720 -> hit_ok only, no miss; restart while two blocks active -> all vld=0, no pulses.
REQ-040 With LANE_BLOCK_GEN_SPEED_EN and speed=3 -> h goes 120,123,...,717,720 (saturated), then expires.
